// File: rtl/riscv_id.sv
// RV32I decode stage: combinational field/immediate decode, early JAL
// resolution, load-use hazard detection and the ID/EX pipeline register.
module riscv_id #(
    parameter logic [31:0] BUBBLE_INSTR   = 32'h0000_0000,
    parameter bit          LOAD_USE_STALL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    input  logic        i_flush,
    output logic [4:0]  o_rs1_addr,
    output logic [4:0]  o_rs2_addr,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    output logic        o_id_jmp,
    output logic [31:0] o_id_target,
    output logic        o_stall,
    output logic        o_ex_valid,
    output logic [31:0] o_ex_pc,
    output logic [31:0] o_ex_rs1_data,
    output logic [31:0] o_ex_rs2_data,
    output logic [31:0] o_ex_imm,
    output logic [4:0]  o_ex_rd,
    output logic [3:0]  o_ex_alu_op,
    output logic [1:0]  o_ex_src_a,
    output logic        o_ex_src_imm,
    output logic [2:0]  o_ex_funct3,
    output logic        o_ex_reg_wr,
    output logic        o_ex_mem_rd,
    output logic        o_ex_mem_wr,
    output logic        o_ex_branch,
    output logic        o_ex_jal,
    output logic        o_ex_jalr,
    output logic        o_ex_illegal
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = i_instr[6:0];
    assign rd     = i_instr[11:7];
    assign funct3 = i_instr[14:12];
    assign rs1    = i_instr[19:15];
    assign rs2    = i_instr[24:20];
    assign funct7 = i_instr[31:25];

    assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign imm_u = {i_instr[31:12], 12'h000};
    assign imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    assign o_rs1_addr = rs1;
    assign o_rs2_addr = rs2;

    // Decoded control for the instruction currently in ID.
    logic [31:0] dec_imm;
    logic [3:0]  dec_alu_op;
    logic [1:0]  dec_src_a;
    logic        dec_src_imm, dec_wr, dec_mem_rd, dec_mem_wr;
    logic        dec_branch, dec_jal, dec_jalr, dec_illegal;
    logic        uses_rs1, uses_rs2;

    // Opcode/funct decode into EX control fields and operand usage.
    always_comb begin
        dec_imm     = 32'h0;
        dec_alu_op  = 4'b0000;
        dec_src_a   = 2'd0;
        dec_src_imm = 1'b0;
        dec_wr      = 1'b0;
        dec_mem_rd  = 1'b0;
        dec_mem_wr  = 1'b0;
        dec_branch  = 1'b0;
        dec_jal     = 1'b0;
        dec_jalr    = 1'b0;
        dec_illegal = 1'b0;
        uses_rs1    = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
        uses_rs2    = (opcode == OPC_OP || opcode == OPC_STORE || opcode == OPC_BRANCH);
        case (opcode)
            OPC_OP: begin
                dec_alu_op = {funct7[5], funct3};
                dec_wr     = 1'b1;
                if (funct7 != 7'b0000000 && funct7 != 7'b0100000)
                    dec_illegal = 1'b1;
                else if (funct7[5] && funct3 != 3'b000 && funct3 != 3'b101)
                    dec_illegal = 1'b1;
            end
            OPC_OPIMM: begin
                dec_alu_op  = {(funct3 == 3'b101) & funct7[5], funct3};
                dec_src_imm = 1'b1;
                dec_wr      = 1'b1;
                // Shift immediates carry only the shift amount; funct7 lives in the upper bits.
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    dec_imm = {27'h0, i_instr[24:20]};
                else
                    dec_imm = imm_i;
            end
            OPC_LUI: begin
                dec_src_a = 2'd2; dec_src_imm = 1'b1; dec_imm = imm_u; dec_wr = 1'b1;
            end
            OPC_AUIPC: begin
                dec_src_a = 2'd1; dec_src_imm = 1'b1; dec_imm = imm_u; dec_wr = 1'b1;
            end
            OPC_LOAD: begin
                dec_src_imm = 1'b1; dec_imm = imm_i; dec_wr = 1'b1; dec_mem_rd = 1'b1;
            end
            OPC_STORE: begin
                dec_src_imm = 1'b1; dec_imm = imm_s; dec_mem_wr = 1'b1;
            end
            OPC_BRANCH: begin
                dec_branch = 1'b1; dec_imm = imm_b;
            end
            OPC_JAL: begin
                dec_jal = 1'b1; dec_imm = imm_j; dec_wr = 1'b1;
            end
            OPC_JALR: begin
                dec_jalr = 1'b1; dec_src_imm = 1'b1; dec_imm = imm_i; dec_wr = 1'b1;
            end
            OPC_FENCE, OPC_SYSTEM: begin
                dec_imm = imm_i;
            end
            default: dec_illegal = 1'b1;
        endcase
        // An illegal instruction travels as a valid no-op with no side effects.
        if (dec_illegal) begin
            dec_wr     = 1'b0;
            dec_mem_rd = 1'b0;
            dec_mem_wr = 1'b0;
        end
    end

    // Registered ID/EX state.
    logic [31:0] ex_pc_q, ex_rs1_q, ex_rs2_q, ex_imm_q;
    logic [4:0]  ex_rd_q;
    logic [3:0]  ex_alu_op_q;
    logic [1:0]  ex_src_a_q;
    logic [2:0]  ex_funct3_q;
    logic        ex_valid_q, ex_src_imm_q, ex_reg_wr_q, ex_mem_rd_q, ex_mem_wr_q;
    logic        ex_branch_q, ex_jal_q, ex_jalr_q, ex_illegal_q;

    logic dv, hz, load_d;

    assign dv = (i_instr != BUBBLE_INSTR) && !i_flush;
    assign hz = LOAD_USE_STALL && dv && ex_valid_q && ex_mem_rd_q && (ex_rd_q != 5'd0) &&
                ((uses_rs1 && ex_rd_q == rs1) || (uses_rs2 && ex_rd_q == rs2));
    assign load_d = dv && !hz;

    assign o_stall     = hz;
    assign o_id_jmp    = dv && !hz && (opcode == OPC_JAL);
    assign o_id_target = i_pc + imm_j;

    // ID/EX register: decoded fields when issuing, otherwise a cleared bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || !load_d) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= 32'h0;
            ex_rs1_q     <= 32'h0;
            ex_rs2_q     <= 32'h0;
            ex_imm_q     <= 32'h0;
            ex_rd_q      <= 5'd0;
            ex_alu_op_q  <= 4'd0;
            ex_src_a_q   <= 2'd0;
            ex_src_imm_q <= 1'b0;
            ex_funct3_q  <= 3'd0;
            ex_reg_wr_q  <= 1'b0;
            ex_mem_rd_q  <= 1'b0;
            ex_mem_wr_q  <= 1'b0;
            ex_branch_q  <= 1'b0;
            ex_jal_q     <= 1'b0;
            ex_jalr_q    <= 1'b0;
            ex_illegal_q <= 1'b0;
        end else begin
            ex_valid_q   <= 1'b1;
            ex_pc_q      <= i_pc;
            ex_rs1_q     <= i_rs1_data;
            ex_rs2_q     <= i_rs2_data;
            ex_imm_q     <= dec_imm;
            ex_rd_q      <= rd;
            ex_alu_op_q  <= dec_alu_op;
            ex_src_a_q   <= dec_src_a;
            ex_src_imm_q <= dec_src_imm;
            ex_funct3_q  <= funct3;
            ex_reg_wr_q  <= dec_wr && (rd != 5'd0);
            ex_mem_rd_q  <= dec_mem_rd;
            ex_mem_wr_q  <= dec_mem_wr;
            ex_branch_q  <= dec_branch;
            ex_jal_q     <= dec_jal;
            ex_jalr_q    <= dec_jalr;
            ex_illegal_q <= dec_illegal;
        end
    end

    assign o_ex_valid    = ex_valid_q;
    assign o_ex_pc       = ex_pc_q;
    assign o_ex_rs1_data = ex_rs1_q;
    assign o_ex_rs2_data = ex_rs2_q;
    assign o_ex_imm      = ex_imm_q;
    assign o_ex_rd       = ex_rd_q;
    assign o_ex_alu_op   = ex_alu_op_q;
    assign o_ex_src_a    = ex_src_a_q;
    assign o_ex_src_imm  = ex_src_imm_q;
    assign o_ex_funct3   = ex_funct3_q;
    assign o_ex_reg_wr   = ex_reg_wr_q;
    assign o_ex_mem_rd   = ex_mem_rd_q;
    assign o_ex_mem_wr   = ex_mem_wr_q;
    assign o_ex_branch   = ex_branch_q;
    assign o_ex_jal      = ex_jal_q;
    assign o_ex_jalr     = ex_jalr_q;
    assign o_ex_illegal  = ex_illegal_q;
endmodule

// File: tb/tb_riscv_id.sv
// Directed testbench for riscv_id with hand-computed expected values.
module tb_riscv_id;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_pc, i_instr, i_rs1_data, i_rs2_data;
    logic        i_flush;
    logic [4:0]  o_rs1_addr, o_rs2_addr, o_ex_rd;
    logic        o_id_jmp, o_stall, o_ex_valid, o_ex_src_imm, o_ex_reg_wr;
    logic        o_ex_mem_rd, o_ex_mem_wr, o_ex_branch, o_ex_jal, o_ex_jalr, o_ex_illegal;
    logic [31:0] o_id_target, o_ex_pc, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm;
    logic [3:0]  o_ex_alu_op;
    logic [1:0]  o_ex_src_a;
    logic [2:0]  o_ex_funct3;

    int total  = 0;
    int passed = 0;

    riscv_id dut (
        .clk(clk), .rst(rst), .i_pc(i_pc), .i_instr(i_instr), .i_flush(i_flush),
        .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
        .o_id_jmp(o_id_jmp), .o_id_target(o_id_target), .o_stall(o_stall),
        .o_ex_valid(o_ex_valid), .o_ex_pc(o_ex_pc), .o_ex_rs1_data(o_ex_rs1_data),
        .o_ex_rs2_data(o_ex_rs2_data), .o_ex_imm(o_ex_imm), .o_ex_rd(o_ex_rd),
        .o_ex_alu_op(o_ex_alu_op), .o_ex_src_a(o_ex_src_a), .o_ex_src_imm(o_ex_src_imm),
        .o_ex_funct3(o_ex_funct3), .o_ex_reg_wr(o_ex_reg_wr), .o_ex_mem_rd(o_ex_mem_rd),
        .o_ex_mem_wr(o_ex_mem_wr), .o_ex_branch(o_ex_branch), .o_ex_jal(o_ex_jal),
        .o_ex_jalr(o_ex_jalr), .o_ex_illegal(o_ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Present an instruction shortly after a rising edge.
    task automatic present(input logic [31:0] pc, input logic [31:0] instr, input logic flush);
        i_pc = pc; i_instr = instr; i_flush = flush;
        #1;
        $display("pc=0x%08h instr=0x%08h flush=%0b stall=%0b jmp=%0b", pc, instr, flush, o_stall, o_id_jmp);
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; i_flush = 1'b0; i_rs1_data = 32'h0; i_rs2_data = 32'h0;
        i_pc = 32'h0; i_instr = 32'h0050_0093;             // ADDI x1,x0,5
        tick(); tick();
        check("reset_valid", {31'h0, o_ex_valid}, 32'h0);
        check("reset_rs1_addr_comb", {27'h0, o_rs1_addr}, 32'h0);

        // First instruction after reset decodes normally.
        #2 rst = 1'b0;
        tick();
        check("addi_valid", {31'h0, o_ex_valid}, 32'h1);
        check("addi_rd", {27'h0, o_ex_rd}, 32'h1);
        check("addi_imm", o_ex_imm, 32'h5);
        check("addi_alu", {28'h0, o_ex_alu_op}, 32'h0);
        check("addi_src_imm", {31'h0, o_ex_src_imm}, 32'h1);
        check("addi_reg_wr", {31'h0, o_ex_reg_wr}, 32'h1);

        // JAL x1,-8 at 0x100.
        present(32'h100, 32'hFF9F_F0EF, 1'b0);
        check("jal_jmp", {31'h0, o_id_jmp}, 32'h1);
        check("jal_target", o_id_target, 32'h0000_00F8);
        tick();
        check("jal_ex_jal", {31'h0, o_ex_jal}, 32'h1);
        check("jal_ex_rd", {27'h0, o_ex_rd}, 32'h1);
        check("jal_ex_pc", o_ex_pc, 32'h100);

        // Load-use: LW x5,0(x2) then ADD x6,x5,x7.
        present(32'h200, 32'h0001_2283, 1'b0);
        tick();
        check("lw_mem_rd", {31'h0, o_ex_mem_rd}, 32'h1);
        check("lw_funct3", {29'h0, o_ex_funct3}, 32'h2);
        i_rs1_data = 32'h1234_5678; i_rs2_data = 32'h0000_0777;
        present(32'h204, 32'h0072_8333, 1'b0);
        check("lu_stall", {31'h0, o_stall}, 32'h1);
        check("lu_rs1_addr", {27'h0, o_rs1_addr}, 32'h5);
        check("lu_rs2_addr", {27'h0, o_rs2_addr}, 32'h7);
        tick();
        check("lu_bubble", {31'h0, o_ex_valid}, 32'h0);
        present(32'h204, 32'h0072_8333, 1'b0);
        check("lu_nostall", {31'h0, o_stall}, 32'h0);
        tick();
        check("add_valid", {31'h0, o_ex_valid}, 32'h1);
        check("add_rs1_data", o_ex_rs1_data, 32'h1234_5678);
        check("add_rs2_data", o_ex_rs2_data, 32'h0000_0777);
        check("add_rd", {27'h0, o_ex_rd}, 32'h6);

        // LW x0 followed by a reader of x0 must not stall.
        present(32'h300, 32'h0001_2003, 1'b0);
        tick();
        check("lwx0_reg_wr", {31'h0, o_ex_reg_wr}, 32'h0);
        present(32'h304, 32'h0070_0333, 1'b0);
        check("x0_nostall", {31'h0, o_stall}, 32'h0);
        tick();

        // Flush priority with a hazard-producing load in EX.
        present(32'h400, 32'h0001_2283, 1'b0);           // LW x5
        tick();
        present(32'h404, 32'hFF9F_F0EF, 1'b1);           // JAL under flush
        check("flush_jmp", {31'h0, o_id_jmp}, 32'h0);
        present(32'h404, 32'h0072_8333, 1'b1);           // dependent ADD under flush
        check("flush_stall", {31'h0, o_stall}, 32'h0);
        tick();
        check("flush_bubble", {31'h0, o_ex_valid}, 32'h0);

        // Bubble instruction and all-ones illegal.
        present(32'h500, 32'h0000_0000, 1'b0);
        tick();
        check("bubble_valid", {31'h0, o_ex_valid}, 32'h0);
        check("bubble_illegal", {31'h0, o_ex_illegal}, 32'h0);
        present(32'h504, 32'hFFFF_FFFF, 1'b0);
        tick();
        check("ill_valid", {31'h0, o_ex_valid}, 32'h1);
        check("ill_illegal", {31'h0, o_ex_illegal}, 32'h1);
        check("ill_reg_wr", {31'h0, o_ex_reg_wr}, 32'h0);

        // Immediates and ALU op encodings.
        present(32'h600, 32'h4032_5193, 1'b0);           // SRAI x3,x4,3
        tick();
        check("srai_alu", {28'h0, o_ex_alu_op}, 32'hD);
        check("srai_imm", o_ex_imm, 32'h3);
        present(32'h604, 32'hFE11_2E23, 1'b0);           // SW x1,-4(x2)
        tick();
        check("sw_imm", o_ex_imm, 32'hFFFF_FFFC);
        check("sw_mem_wr", {31'h0, o_ex_mem_wr}, 32'h1);
        check("sw_reg_wr", {31'h0, o_ex_reg_wr}, 32'h0);
        present(32'h608, 32'hFE20_8FE3, 1'b0);           // BEQ x1,x2,-2
        tick();
        check("beq_imm", o_ex_imm, 32'hFFFF_FFFE);
        check("beq_branch", {31'h0, o_ex_branch}, 32'h1);
        present(32'h60C, 32'hABCD_E2B7, 1'b0);           // LUI x5,0xABCDE
        tick();
        check("lui_imm", o_ex_imm, 32'hABCD_E000);
        check("lui_src_a", {30'h0, o_ex_src_a}, 32'h2);
        present(32'h610, 32'h4031_00B3, 1'b0);           // SUB x1,x2,x3
        tick();
        check("sub_alu", {28'h0, o_ex_alu_op}, 32'h8);
        check("sub_illegal", {31'h0, o_ex_illegal}, 32'h0);
        present(32'h614, 32'h0231_00B3, 1'b0);           // MUL encoding, not RV32I
        tick();
        check("mul_illegal", {31'h0, o_ex_illegal}, 32'h1);
        check("mul_reg_wr", {31'h0, o_ex_reg_wr}, 32'h0);

        // Reset mid-stream clears ID/EX without waiting for a clock.
        present(32'h700, 32'h0050_0093, 1'b0);
        tick();
        check("pre_rst_valid", {31'h0, o_ex_valid}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", {31'h0, o_ex_valid}, 32'h0);
        check("async_rst_rd", {27'h0, o_ex_rd}, 32'h0);
        #1 rst = 1'b0;
        tick();
        check("post_rst_valid", {31'h0, o_ex_valid}, 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/riscv_id.md
Name: riscv_id

Overview:
RV32I decode stage that sits directly downstream of instruction fetch. It consumes the fetched PC/instruction pair and reads the external register file. It resolves JAL early, returning jump and target to fetch, and detects load-use hazards to stall fetch. It registers the decoded fields into the ID/EX pipeline register that feeds the execute stage.

Parameters:
BUBBLE_INSTR, 32'h0000_0000, instruction word that fetch emits when it has nothing valid; decoded as a bubble, never as illegal
LOAD_USE_STALL, 1, 1 = generate load-use stall; 0 = never stall (EX forwards from MEM)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_pc  in  32  PC of i_instr
i_instr  in  32  fetched instruction
i_flush  in  1  EX-stage jump taken: squash the instruction in ID
o_rs1_addr  out  5  register-file read address A (combinational from i_instr[19:15])
o_rs2_addr  out  5  register-file read address B (i_instr[24:20])
i_rs1_data  in  32  register-file data A, same-cycle combinational read
i_rs2_data  in  32  register-file data B
o_id_jmp  out  1  JAL resolved in ID (combinational)
o_id_target  out  32  JAL target = i_pc + J-immediate
o_stall  out  1  load-use stall request to fetch (combinational)
o_ex_valid  out  1  ID/EX holds a real instruction
o_ex_pc  out  32  PC
o_ex_rs1_data  out  32  operand A
o_ex_rs2_data  out  32  operand B / store data
o_ex_imm  out  32  sign-extended immediate
o_ex_rd  out  5  destination register
o_ex_alu_op  out  4  {funct7[5] or 0, funct3}: ADD=0000 SUB=1000 SLL=0001 SLT=0010 SLTU=0011 XOR=0100 SRL=0101 SRA=1101 OR=0110 AND=0111
o_ex_src_a  out  2  0 = rs1, 1 = pc, 2 = zero
o_ex_src_imm  out  1  operand B is the immediate
o_ex_funct3  out  3  branch condition / memory size
o_ex_reg_wr  out  1  writes rd (forced 0 when rd = x0)
o_ex_mem_rd  out  1  load
o_ex_mem_wr  out  1  store
o_ex_branch  out  1  conditional branch
o_ex_jal  out  1  JAL; EX writes pc+4 to rd
o_ex_jalr  out  1  JALR; EX computes target (rs1+imm)&~1 and writes pc+4
o_ex_illegal  out  1  unsupported opcode/funct encoding

Behaviour:
- Reset (async, rst=1): all o_ex_* cleared to 0, so o_ex_valid=0. Combinational outputs follow their inputs during reset.
- Decode valid (dv) = (i_instr != BUBBLE_INSTR) & ~i_flush.
- Immediates by type: I, S, B, U, J per RV32I, all sign-extended to 32 bits. R-type imm = 0.
- Opcode mapping:
  - OP/OP-IMM → alu_op from funct3 plus funct7[5]. For OP-IMM, funct7[5] is used only when funct3=101.
  - LUI → src_a=2, ADD, imm.
  - AUIPC → src_a=1, ADD, imm.
  - LOAD/STORE → ADD, imm.
  - BRANCH → branch=1, funct3 passed through.
  - FENCE/SYSTEM → valid NOP: reg_wr=0.
  - Anything else → illegal=1, valid=1, reg_wr=mem_rd=mem_wr=0.
  - OP with funct7 not in {0000000, 0100000}, or an SUB/SRA funct7 on any other funct3 → illegal.
- Load-use hazard, hz:
  - Condition: LOAD_USE_STALL & dv & o_ex_valid & o_ex_mem_rd & o_ex_rd!=0.
  - And o_ex_rd matches rs1 (when the type uses rs1: all except LUI/AUIPC/JAL) or rs2 (R/S/B types).
- o_stall = hz.
- o_id_jmp = dv & ~hz & opcode==JAL. o_id_target = i_pc + immJ, computed modulo 2^32.
- ID/EX update each clk:
  - If i_flush or hz or ~dv: load a bubble (valid=0, all control 0, data don't-care but cleared).
  - Otherwise: load decoded fields.
  - i_flush has priority over hz.
- During a stall, fetch re-presents the same pc/instr next cycle. ID holds no state of its own, so the single inserted bubble resolves the hazard in exactly one cycle.
- Latency: one cycle from i_instr to o_ex_*. o_id_jmp, o_stall and o_rs*_addr are zero-latency.
- Reset asserted mid-stream: ID/EX clears immediately (async). First post-reset instruction decodes normally.

Test Plan:
- Reset: hold rst=1 with i_instr=ADDI x1,x0,5 → o_ex_valid=0. After rst release, the next clk gives o_ex_valid=1, rd=1, imm=5, alu_op=0000, src_imm=1.
- JAL: i_pc=0x100, i_instr=JAL x1,-8 (0xFF9FF0EF) → o_id_jmp=1, o_id_target=0xF8. Next cycle o_ex_jal=1, o_ex_rd=1.
- Load-use: LW x5,0(x2) then ADD x6,x5,x7 → cycle 2 o_stall=1 and ID/EX bubble. Cycle 3 the re-presented ADD issues with o_ex_rs1_data = i_rs1_data. LW x0 followed by a user of x0 → no stall.
- Flush priority: i_flush=1 with JAL and an active hazard → o_id_jmp=0, o_stall=0, next o_ex_valid=0.
- Bubble/illegal: i_instr=0x00000000 → o_ex_valid=0, illegal=0. i_instr=0xFFFFFFFF → valid=1, illegal=1, reg_wr=0.
- Immediates: SRAI x3,x4,3 (0x40325193) → alu_op=1101, imm=3. SW x1,-4(x2) (0xFE112E23) → imm=0xFFFFFFFC, mem_wr=1. BEQ offset -2 → imm=0xFFFFFFFE. LUI 0xABCDE → imm=0xABCDE000, src_a=2.
